uart_tx_buffered: RTL and testbench

Buffered 8N1 UART transmitter that sits directly downstream of the CPU core's store path. It takes the byte write strobe the CPU raises on a store to the UART address, queues bytes in an internal FIFO and serialises them onto the FPGA `uart_tx` pin. Because of the queue, the CPU can issue stores back to back without waiting out a full character time. Status outputs let the core poll fill level and detect dropped bytes.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_tx_buffered.sv | 138 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and the transmitter state type for the buffered UART.
package uart_pkg;

    localparam logic [31:0] UART_ADDR            = 32'h1000_0000;
    localparam int          DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with registered pointers and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are AW bits wide, so increments wrap modulo DEPTH for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a registered-output serialiser.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH        = 16
) (
    input  logic                   sysclk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   uart_tx,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   overflow
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    uart_tx_state_t state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           tx_q, tx_d;
    logic           overflow_q, overflow_d;
    logic           fifo_pop;
    logic [7:0]     fifo_dout;
    logic           last_tick;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (sysclk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (fifo_pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign uart_tx   = tx_q;
    assign busy      = (state_q != IDLE);
    assign overflow  = overflow_q;
    assign last_tick = (baud_q == BAUD_MAX);

    always_comb begin
        overflow_d = overflow_q || (wr_en && full);
    end

    // Next-state logic; the STOP final cycle may reload directly so frames abut.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_dout;
                    bitcnt_d = '0;
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (last_tick) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (last_tick) begin
                    baud_d   = '0;
                    shreg_d  = {1'b0, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (last_tick) begin
                    baud_d = '0;
                    if (!empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_dout;
                        bitcnt_d = '0;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is computed from the next state so the pin itself is a flop.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomised scoreboard bench for uart_tx_buffered with a timeline-level reference model.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          sysclk = 1'b0;
    logic          rst    = 1'b1;
    logic          wr_en  = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          uart_tx;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          busy;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH)
    ) dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .uart_tx  (uart_tx),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 sysclk = ~sysclk;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic en, input logic [7:0] d);
        @(negedge sysclk);
        rst     = r;
        wr_en   = en;
        wr_data = d;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 8'h00);
    endtask

    // Reference model: a byte queue plus a transmitter timeline. A pop may
    // happen once a full frame time has passed since the previous pop.
    logic [7:0] model_q [$];
    logic [7:0] sb_q [$];
    int         cyc        = 0;
    int         pop_ok     = 0;
    int         frame_start = -1000;
    logic [7:0] frame_byte = 8'h00;
    logic       model_ovf  = 1'b0;
    logic       model_valid = 1'b0;
    int         peak_count = 0;

    always @(posedge sysclk) begin
        int c;
        c = cyc;
        if (rst) begin
            model_q.delete();
            sb_q.delete();
            model_ovf   = 1'b0;
            frame_start = -1000;
            pop_ok      = 0;
        end else begin
            logic accept;
            accept = wr_en && (model_q.size() < DEPTH);
            if (wr_en && !accept) model_ovf = 1'b1;
            if (model_q.size() > 0 && c >= pop_ok) begin
                frame_byte  = model_q.pop_front();
                frame_start = c + 1;
                pop_ok      = c + FRAME;
            end
            if (accept) begin
                model_q.push_back(wr_data);
                sb_q.push_back(wr_data);
            end
        end
        if (model_q.size() > peak_count) peak_count = model_q.size();
        cyc         = c + 1;
        model_valid = 1'b1;
    end

    always @(negedge sysclk) begin
        if (model_valid) begin
            int   idx;
            logic exp_busy;
            logic exp_tx;
            exp_busy = (cyc >= frame_start) && (cyc < frame_start + FRAME);
            exp_tx   = 1'b1;
            if (exp_busy) begin
                idx = (cyc - frame_start) / CPB;
                if (idx == 0)      exp_tx = 1'b0;
                else if (idx <= 8) exp_tx = frame_byte[idx-1];
            end
            check_output("uart_tx",  int'(uart_tx),  int'(exp_tx));
            check_output("busy",     int'(busy),     int'(exp_busy));
            check_output("count",    int'(count),    model_q.size());
            check_output("empty",    int'(empty),    int'(model_q.size() == 0));
            check_output("full",     int'(full),     int'(model_q.size() == DEPTH));
            check_output("overflow", int'(overflow), int'(model_ovf));
        end
    end

    // Serial monitor: decodes frames from the pin and pops the scoreboard.
    logic       mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_byte   = 8'h00;
    logic       mon_prev   = 1'b1;
    int         frames_seen = 0;

    always @(negedge sysclk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (mon_prev && !uart_tx) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
        end else begin
            mon_cnt++;
        end
        if (mon_active && !rst && (mon_cnt % CPB) == CPB / 2) begin
            int k;
            k = mon_cnt / CPB;
            if (k >= 1 && k <= 8) begin
                mon_byte[k-1] = uart_tx;
            end else if (k == 9) begin
                check_output("stop_bit", int'(uart_tx), 1);
                frames_seen++;
                if (sb_q.size() == 0) begin
                    check_output("unexpected_frame", int'(mon_byte), -1);
                end else begin
                    check_output("frame_data", int'(mon_byte), int'(sb_q.pop_front()));
                end
                mon_active = 1'b0;
            end
        end
        mon_prev = uart_tx;
    end

    initial begin
        int rate;
        int frames_before;

        // Reset for two cycles, then idle.
        apply_stimulus(1'b1, 1'b0, 8'h00);
        apply_stimulus(1'b1, 1'b0, 8'h00);
        idle_cycles(50);

        // Single byte.
        apply_stimulus(1'b0, 1'b1, 8'hA5);
        idle_cycles(60);

        // Burst of three.
        peak_count = 0;
        apply_stimulus(1'b0, 1'b1, 8'h01);
        apply_stimulus(1'b0, 1'b1, 8'h02);
        apply_stimulus(1'b0, 1'b1, 8'h03);
        idle_cycles(140);
        check_output("burst_peak_count", peak_count, 2);

        // Overflow: six writes from empty.
        frames_before = frames_seen;
        apply_stimulus(1'b0, 1'b1, 8'h10);
        apply_stimulus(1'b0, 1'b1, 8'h21);
        apply_stimulus(1'b0, 1'b1, 8'h32);
        apply_stimulus(1'b0, 1'b1, 8'h43);
        apply_stimulus(1'b0, 1'b1, 8'h54);
        apply_stimulus(1'b0, 1'b1, 8'h65);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        check_output("ovf_full", int'(full), 1);
        check_output("ovf_flag", int'(overflow), 1);
        idle_cycles(260);
        check_output("ovf_sticky", int'(overflow), 1);
        check_output("ovf_frames", frames_seen - frames_before, 5);

        // Reset mid-frame during data bit 3 of 0xFF with two bytes queued.
        apply_stimulus(1'b1, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b1, 8'hFF);
        apply_stimulus(1'b0, 1'b1, 8'h5A);
        apply_stimulus(1'b0, 1'b1, 8'hC3);
        idle_cycles(CPB * 4);
        apply_stimulus(1'b1, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        check_output("rst_mid_count", int'(count), 0);
        check_output("rst_mid_busy", int'(busy), 0);
        frames_before = frames_seen;
        idle_cycles(100);
        check_output("rst_mid_no_frames", frames_seen - frames_before, 0);

        // Write exactly on the STOP final cycle with one byte queued.
        apply_stimulus(1'b0, 1'b1, 8'h3C);
        apply_stimulus(1'b0, 1'b1, 8'h96);
        idle_cycles(FRAME - 1);
        apply_stimulus(1'b0, 1'b1, 8'h7E);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        check_output("pushpop_count", int'(count), 1);
        check_output("pushpop_busy", int'(busy), 1);
        idle_cycles(3 * FRAME);

        // Random traffic at varying rates with occasional resets.
        for (int blk = 0; blk < 20; blk++) begin
            rate = $urandom_range(0, 2);
            rate = (rate == 0) ? 2 : (rate == 1) ? 8 : 60;
            for (int i = 0; i < 200; i++) begin
                apply_stimulus($urandom_range(0, 1499) == 0,
                               $urandom_range(0, 99) < rate,
                               8'($urandom_range(0, 255)));
            end
        end

        idle_cycles((DEPTH + 2) * FRAME);
        check_output("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
